// File: rtl/id_ex_if.sv
// Bundles the ID/EX stage's decode inputs, hazard controls, forwarding taps and ALU-side
// outputs so that the stage and its neighbours connect through one port.
interface id_ex_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned OP_W   = 3
);
  logic              stall;
  logic              flush;
  logic              id_valid;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [IMM_W-1:0]  id_imm;
  logic [ADDR_W-1:0] id_rs_addr;
  logic [ADDR_W-1:0] id_rt_addr;
  logic [ADDR_W-1:0] id_rd_addr;
  logic [OP_W-1:0]   id_alu_op;
  logic              id_alu_src;
  logic              id_reg_write;
  logic              exmem_reg_write;
  logic [ADDR_W-1:0] exmem_rd;
  logic [DATA_W-1:0] exmem_result;
  logic              memwb_reg_write;
  logic [ADDR_W-1:0] memwb_rd;
  logic [DATA_W-1:0] memwb_result;
  logic [DATA_W-1:0] alu_input1;
  logic [DATA_W-1:0] alu_input2;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] ex_store_data;
  logic [ADDR_W-1:0] ex_rd;
  logic              ex_reg_write;
  logic              ex_valid;

  modport master (
    output stall, flush, id_valid, id_rs_data, id_rt_data, id_imm, id_rs_addr, id_rt_addr,
           id_rd_addr, id_alu_op, id_alu_src, id_reg_write,
           exmem_reg_write, exmem_rd, exmem_result, memwb_reg_write, memwb_rd, memwb_result,
    input  alu_input1, alu_input2, alu_op, ex_store_data, ex_rd, ex_reg_write, ex_valid
  );

  modport slave (
    input  stall, flush, id_valid, id_rs_data, id_rt_data, id_imm, id_rs_addr, id_rt_addr,
           id_rd_addr, id_alu_op, id_alu_src, id_reg_write,
           exmem_reg_write, exmem_rd, exmem_result, memwb_reg_write, memwb_rd, memwb_result,
    output alu_input1, alu_input2, alu_op, ex_store_data, ex_rd, ex_reg_write, ex_valid
  );
endinterface

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register: captures decoded fields, then forwards from EX/MEM and
// MEM/WB and selects the immediate to drive the ALU inputs during the EX cycle.
module id_ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned OP_W   = 3
) (
  input logic    clk,
  input logic    rst,
  id_ex_if.slave bus
);

  logic              valid_q,     valid_d;
  logic [DATA_W-1:0] rs_data_q,   rs_data_d;
  logic [DATA_W-1:0] rt_data_q,   rt_data_d;
  logic [IMM_W-1:0]  imm_q,       imm_d;
  logic [ADDR_W-1:0] rs_addr_q,   rs_addr_d;
  logic [ADDR_W-1:0] rt_addr_q,   rt_addr_d;
  logic [ADDR_W-1:0] rd_q,        rd_d;
  logic [OP_W-1:0]   op_q,        op_d;
  logic              alu_src_q,   alu_src_d;
  logic              reg_write_q, reg_write_d;

  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;
  logic [DATA_W-1:0] imm_ext;

  // Flush beats stall; reset beats both and lives in the register process.
  always_comb begin
    valid_d     = valid_q;
    rs_data_d   = rs_data_q;
    rt_data_d   = rt_data_q;
    imm_d       = imm_q;
    rs_addr_d   = rs_addr_q;
    rt_addr_d   = rt_addr_q;
    rd_d        = rd_q;
    op_d        = op_q;
    alu_src_d   = alu_src_q;
    reg_write_d = reg_write_q;
    if (bus.flush) begin
      valid_d     = 1'b0;
      rs_data_d   = '0;
      rt_data_d   = '0;
      imm_d       = '0;
      rs_addr_d   = '0;
      rt_addr_d   = '0;
      rd_d        = '0;
      op_d        = '0;
      alu_src_d   = 1'b0;
      reg_write_d = 1'b0;
    end else if (!bus.stall) begin
      valid_d     = bus.id_valid;
      rs_data_d   = bus.id_rs_data;
      rt_data_d   = bus.id_rt_data;
      imm_d       = bus.id_imm;
      rs_addr_d   = bus.id_rs_addr;
      rt_addr_d   = bus.id_rt_addr;
      rd_d        = bus.id_rd_addr;
      op_d        = bus.id_alu_op;
      alu_src_d   = bus.id_alu_src;
      reg_write_d = bus.id_reg_write & bus.id_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      rd_q        <= '0;
      op_q        <= '0;
      alu_src_q   <= 1'b0;
      reg_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      imm_q       <= imm_d;
      rs_addr_q   <= rs_addr_d;
      rt_addr_q   <= rt_addr_d;
      rd_q        <= rd_d;
      op_q        <= op_d;
      alu_src_q   <= alu_src_d;
      reg_write_q <= reg_write_d;
    end
  end

  // Register 0 is hard-wired zero, so a zero destination never forwards; EX/MEM is younger.
  always_comb begin
    fwd_a = rs_data_q;
    if (bus.exmem_reg_write && (bus.exmem_rd != '0) && (bus.exmem_rd == rs_addr_q)) begin
      fwd_a = bus.exmem_result;
    end else if (bus.memwb_reg_write && (bus.memwb_rd != '0) && (bus.memwb_rd == rs_addr_q)) begin
      fwd_a = bus.memwb_result;
    end
  end

  always_comb begin
    fwd_b = rt_data_q;
    if (bus.exmem_reg_write && (bus.exmem_rd != '0) && (bus.exmem_rd == rt_addr_q)) begin
      fwd_b = bus.exmem_result;
    end else if (bus.memwb_reg_write && (bus.memwb_rd != '0) && (bus.memwb_rd == rt_addr_q)) begin
      fwd_b = bus.memwb_result;
    end
  end

  assign imm_ext = {{(DATA_W - IMM_W){imm_q[IMM_W-1]}}, imm_q};

  assign bus.alu_input1    = fwd_a;
  assign bus.alu_input2    = alu_src_q ? imm_ext : fwd_b;
  assign bus.alu_op        = op_q;
  assign bus.ex_store_data = fwd_b;
  assign bus.ex_rd         = rd_q;
  assign bus.ex_reg_write  = reg_write_q;
  assign bus.ex_valid      = valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected EX-cycle outputs are queued with each stimulus step
// and popped for comparison one clock later.
module tb_id_ex_stage;

  typedef struct {
    logic [31:0] in1;
    logic [31:0] in2;
    logic [2:0]  op;
    logic [31:0] store;
    logic [4:0]  rd;
    logic        rw;
    logic        valid;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  id_ex_if bus ();

  id_ex_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_id(input logic v, input logic [31:0] rs_d, input logic [31:0] rt_d,
                          input logic [15:0] imm, input logic [4:0] rs_a, input logic [4:0] rt_a,
                          input logic [4:0] rd, input logic [2:0] op, input logic src,
                          input logic rw);
    bus.id_valid     = v;
    bus.id_rs_data   = rs_d;
    bus.id_rt_data   = rt_d;
    bus.id_imm       = imm;
    bus.id_rs_addr   = rs_a;
    bus.id_rt_addr   = rt_a;
    bus.id_rd_addr   = rd;
    bus.id_alu_op    = op;
    bus.id_alu_src   = src;
    bus.id_reg_write = rw;
  endtask

  task automatic fwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                     input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
    bus.exmem_reg_write = ew;
    bus.exmem_rd        = erd;
    bus.exmem_result    = eres;
    bus.memwb_reg_write = mw;
    bus.memwb_rd        = mrd;
    bus.memwb_result    = mres;
  endtask

  task automatic push(input logic [31:0] in1, input logic [31:0] in2, input logic [2:0] op,
                      input logic [31:0] store, input logic [4:0] rd, input logic rw,
                      input logic valid);
    exp_t e;
    e.in1 = in1; e.in2 = in2; e.op = op; e.store = store; e.rd = rd; e.rw = rw; e.valid = valid;
    sb.push_back(e);
  endtask

  // One clock, then compare the oldest queued expectation away from the edge.
  task automatic step(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL %s: observed=empty_queue expected=entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      cmp({tag, ".in1"},   bus.alu_input1,    e.in1);
      cmp({tag, ".in2"},   bus.alu_input2,    e.in2);
      cmp({tag, ".op"},    32'(bus.alu_op),   32'(e.op));
      cmp({tag, ".store"}, bus.ex_store_data, e.store);
      cmp({tag, ".rd"},    32'(bus.ex_rd),    32'(e.rd));
      cmp({tag, ".rw"},    32'(bus.ex_reg_write), 32'(e.rw));
      cmp({tag, ".valid"}, 32'(bus.ex_valid), 32'(e.valid));
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    drive_id(1'b0, 0, 0, 16'h0, 0, 0, 0, 3'd0, 1'b0, 1'b0);
    fwd(1'b0, 0, 0, 1'b0, 0, 0);
    push(0, 0, 3'd0, 0, 0, 1'b0, 1'b0);
    step("reset");

    rst = 1'b0;
    drive_id(1'b1, 10, 5, 16'h0, 1, 2, 4, 3'b000, 1'b0, 1'b1);
    push(10, 5, 3'b000, 5, 4, 1'b1, 1'b1);
    step("basic_load");

    drive_id(1'b1, 10, 5, 16'hFFFB, 1, 2, 5, 3'b010, 1'b1, 1'b1);
    push(10, 32'hFFFF_FFFB, 3'b010, 5, 5, 1'b1, 1'b1);
    step("imm_neg");

    drive_id(1'b1, 10, 5, 16'h0007, 1, 2, 5, 3'b010, 1'b1, 1'b1);
    push(10, 7, 3'b010, 5, 5, 1'b1, 1'b1);
    step("imm_pos");

    drive_id(1'b1, 1, 2, 16'h0, 3, 3, 6, 3'b001, 1'b0, 1'b1);
    fwd(1'b1, 3, 100, 1'b1, 3, 200);
    push(100, 100, 3'b001, 100, 6, 1'b1, 1'b1);
    step("fwd_exmem_prio");

    // Hold the stage and vary only the forwarding taps.
    bus.stall = 1'b1;
    fwd(1'b0, 3, 100, 1'b1, 3, 200);
    push(200, 200, 3'b001, 200, 6, 1'b1, 1'b1);
    step("fwd_memwb");

    fwd(1'b1, 0, 100, 1'b1, 3, 200);
    push(200, 200, 3'b001, 200, 6, 1'b1, 1'b1);
    step("fwd_exmem_rd0");

    fwd(1'b1, 0, 100, 1'b0, 3, 200);
    push(1, 2, 3'b001, 2, 6, 1'b1, 1'b1);
    step("fwd_none");

    bus.stall = 1'b0;
    drive_id(1'b1, 77, 8, 16'h0, 0, 9, 7, 3'b011, 1'b0, 1'b1);
    fwd(1'b1, 0, 55, 1'b1, 0, 66);
    push(77, 8, 3'b011, 8, 7, 1'b1, 1'b1);
    step("addr0_no_fwd");

    drive_id(1'b1, 1, 2, 16'h8000, 7, 8, 9, 3'b100, 1'b1, 1'b1);
    fwd(1'b1, 8, 300, 1'b1, 7, 400);
    push(400, 32'hFFFF_8000, 3'b100, 300, 9, 1'b1, 1'b1);
    step("split_fwd");

    fwd(1'b0, 0, 0, 1'b0, 0, 0);
    drive_id(1'b1, 11, 12, 16'h0, 1, 2, 10, 3'b101, 1'b0, 1'b1);
    push(11, 12, 3'b101, 12, 10, 1'b1, 1'b1);
    step("pre_stall");

    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_id(1'b1, 32'(99 + i), 32'(50 + i), 16'h0, 1, 2, 20, 3'b111, 1'b0, 1'b0);
      push(11, 12, 3'b101, 12, 10, 1'b1, 1'b1);
      step("stall_hold");
    end
    bus.stall = 1'b0;
    push(101, 52, 3'b111, 52, 20, 1'b0, 1'b1);
    step("stall_release");

    bus.stall = 1'b1;
    bus.flush = 1'b1;
    drive_id(1'b1, 5, 6, 16'h1234, 1, 2, 3, 3'b110, 1'b1, 1'b1);
    fwd(1'b1, 0, 55, 1'b0, 0, 0);
    push(0, 0, 3'd0, 0, 0, 1'b0, 1'b0);
    step("flush_over_stall");

    bus.stall = 1'b0;
    bus.flush = 1'b0;
    fwd(1'b0, 0, 0, 1'b0, 0, 0);
    push(5, 32'h0000_1234, 3'b110, 6, 3, 1'b1, 1'b1);
    step("reload");

    bus.flush = 1'b1;
    push(0, 0, 3'd0, 0, 0, 1'b0, 1'b0);
    step("flush_only");

    bus.flush = 1'b0;
    push(5, 32'h0000_1234, 3'b110, 6, 3, 1'b1, 1'b1);
    step("reload2");

    bus.stall = 1'b1;
    rst = 1'b1;
    push(0, 0, 3'd0, 0, 0, 1'b0, 1'b0);
    step("rst_in_stall");

    rst = 1'b0;
    bus.stall = 1'b0;
    drive_id(1'b0, 3, 4, 16'h0, 1, 2, 7, 3'b110, 1'b0, 1'b1);
    push(3, 4, 3'b110, 4, 7, 1'b0, 1'b0);
    step("invalid_rw_masked");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register sitting directly upstream of the ALU.
- Captures decoded operands, immediate, register addresses and control each cycle.
- Applies EX/MEM and MEM/WB forwarding and immediate selection, then drives the ALU's input1, input2 and op.
- Supports stall (hold) and flush (bubble insertion) from the hazard unit.

Parameters:
- DATA_W, 32, operand/result width; equals ALU input width.
- ADDR_W, 5, register address width; register 0 is hard-wired zero.
- IMM_W, 16, raw immediate width; sign-extended to DATA_W.
- OP_W, 3, ALU operation code width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold all stage registers this cycle.
- flush  in  1  load a bubble this cycle.
- id_valid  in  1  decode stage presents a real instruction.
- id_rs_data  in  DATA_W  register-file read data A.
- id_rt_data  in  DATA_W  register-file read data B.
- id_imm  in  IMM_W  raw immediate.
- id_rs_addr  in  ADDR_W  source A register number.
- id_rt_addr  in  ADDR_W  source B register number.
- id_rd_addr  in  ADDR_W  destination register number.
- id_alu_op  in  OP_W  ALU operation.
- id_alu_src  in  1  1 = input2 takes sign-extended immediate.
- id_reg_write  in  1  instruction writes a register.
- exmem_reg_write  in  1  EX/MEM stage will write back.
- exmem_rd  in  ADDR_W  EX/MEM destination register.
- exmem_result  in  DATA_W  EX/MEM result.
- memwb_reg_write  in  1  MEM/WB stage will write back.
- memwb_rd  in  ADDR_W  MEM/WB destination register.
- memwb_result  in  DATA_W  MEM/WB result.
- alu_input1  out  DATA_W  to ALU input1.
- alu_input2  out  DATA_W  to ALU input2.
- alu_op  out  OP_W  to ALU op.
- ex_store_data  out  DATA_W  forwarded rt value, for stores.
- ex_rd  out  ADDR_W  registered destination register.
- ex_reg_write  out  1  registered reg_write AND valid.
- ex_valid  out  1  stage holds a real instruction.

Behaviour:
Register update priority on each rising clk edge is rst > flush > stall > load.
- rst: all stage registers cleared to 0.
  - Result next cycle: ex_valid=0, ex_reg_write=0, ex_rd=0, alu_op=0.
  - Forwarding is inhibited because address 0 never forwards, so alu_input1, alu_input2 and ex_store_data all read 0.
- flush: identical to reset of the stage registers; a bubble with all fields 0.
  - flush and stall asserted together: flush wins.
- stall (without flush): every stage register holds its value.
  - Outputs may still change combinationally if forwarding inputs change.
- Load (neither flush nor stall): all id_* fields captured.
  - valid register takes id_valid.
  - reg_write register takes id_reg_write AND id_valid.
- Latency: one cycle from id_* capture to the ALU inputs; forwarding is combinational within the EX cycle.
- Forwarding for A, applied to the registered rs_addr:
  - If exmem_reg_write=1, exmem_rd!=0 and exmem_rd==rs_addr: use exmem_result.
  - Else if memwb_reg_write=1, memwb_rd!=0 and memwb_rd==rs_addr: use memwb_result.
  - Else use the registered rs_data.
  - EX/MEM has priority over MEM/WB when both match.
- Forwarding for B: same rule on the registered rt_addr, giving fwd_b.
- Output selection:
  - ex_store_data = fwd_b.
  - alu_input2 = alu_src ? sign_extend(imm) : fwd_b.
  - alu_input1 = fwd_a.
- Sign extension: bit IMM_W-1 is replicated into bits DATA_W-1..IMM_W.
- No arithmetic in this block; op is passed through unmodified.
- ex_rd and alu_op are registered copies; they are zero when a bubble is held.
- Reset asserted mid-stall clears the stage; stall does not block reset.

Test Plan:
- Reset, then load rs_data=10, rt_data=5, op=3'b000, alu_src=0 -> next cycle alu_input1=10, alu_input2=5, alu_op=000, ex_valid=1.
- Load alu_src=1, imm=16'hFFFB -> alu_input2=32'hFFFFFFFB; imm=16'h0007 -> alu_input2=7; ex_store_data equals rt_data in both cases.
- rs_addr=3, rt_addr=3 with exmem (we=1, rd=3, result=100) and memwb (we=1, rd=3, result=200) -> input1=100, input2=100; drop exmem_reg_write -> both 200; set exmem_rd=0 -> no EX/MEM forwarding.
- rs_addr=0 with exmem_rd=0, exmem_reg_write=1, result=55 -> alu_input1 = registered rs_data, not 55.
- Stall for 3 cycles with id_* inputs changing -> alu_input1, alu_op and ex_rd unchanged; release stall -> new values appear one cycle later.
- stall=1 and flush=1 together with id_valid=1, reg_write=1 -> next cycle ex_valid=0, ex_reg_write=0, alu_op=0; rst during stall -> all outputs 0 next cycle.
